// File: rtl/dm_unit.sv
// dm_unit: M-stage data memory with byte/half/word loads and stores,
// address-fault detection, and captured fault PC and saturating fault count.
// The access interface has no valid/ready handshake. Every cycle presents
// exactly one access, or "no access" when MemOp_M is reserved and
// MemWrite_M=0. Loads resolve combinationally. Stores commit at the next
// rising edge.
module dm_unit #(
  parameter int ADDR_BITS = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite_M,
  input  logic [2:0]  MemOp_M,
  input  logic [31:0] Addr_M,
  input  logic [31:0] WD_M,
  input  logic [31:0] PC_M,
  output logic [31:0] RD_M,
  output logic        AddrErr_M,
  output logic [31:0] ErrPC,
  output logic [7:0]  ErrCnt
);

  localparam int IDX_BITS = ADDR_BITS - 2;
  localparam int WORDS    = 1 << IDX_BITS;

  localparam logic [2:0] OP_W  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_HU = 3'b010;
  localparam logic [2:0] OP_B  = 3'b011;
  localparam logic [2:0] OP_BU = 3'b100;

  logic [31:0]         w_words [WORDS];
  logic [IDX_BITS-1:0] w_idx;
  logic [31:0]         w_word;
  logic                w_reserved;
  logic                w_access;
  logic                w_misalign;
  logic                w_oor;
  logic                w_bad_store;
  logic [15:0]         w_half;
  logic [7:0]          w_byte;
  logic [3:0]          w_be;
  logic [31:0]         w_wdata;
  logic [31:0]         w_merged;
  logic                w_we;
  logic [31:0]         r_err_pc;
  logic [7:0]          r_err_cnt;

  assign w_idx  = Addr_M[ADDR_BITS-1:2];
  assign w_word = w_words[w_idx];

  // Fault classification. A reserved op without a store is a bubble and never faults.
  always_comb begin
    w_reserved  = (MemOp_M > OP_BU);
    w_access    = MemWrite_M | ~w_reserved;
    w_misalign  = ((MemOp_M == OP_W) && (Addr_M[1:0] != 2'b00)) ||
                  (((MemOp_M == OP_H) || (MemOp_M == OP_HU)) && Addr_M[0]);
    w_oor       = |(Addr_M >> ADDR_BITS);
    w_bad_store = MemWrite_M & w_reserved;
    AddrErr_M   = w_access & (w_misalign | w_oor | w_bad_store);
  end

  // Load path: lane select and sign/zero extension, forced to zero on faults and bubbles.
  always_comb begin
    w_half = Addr_M[1] ? w_word[31:16] : w_word[15:0];
    case (Addr_M[1:0])
      2'd0:    w_byte = w_word[7:0];
      2'd1:    w_byte = w_word[15:8];
      2'd2:    w_byte = w_word[23:16];
      default: w_byte = w_word[31:24];
    endcase
    RD_M = '0;
    if (!AddrErr_M) begin
      case (MemOp_M)
        OP_W:    RD_M = w_word;
        OP_H:    RD_M = {{16{w_half[15]}}, w_half};
        OP_HU:   RD_M = {16'b0, w_half};
        OP_B:    RD_M = {{24{w_byte[7]}}, w_byte};
        OP_BU:   RD_M = {24'b0, w_byte};
        default: RD_M = '0;
      endcase
    end
  end

  // Store path: byte-lane enables plus replicated data, merged with the current word.
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = WD_M;
    case (MemOp_M)
      OP_W: w_be = 4'b1111;
      OP_H, OP_HU: begin
        w_be    = Addr_M[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{WD_M[15:0]}};
      end
      OP_B, OP_BU: begin
        w_be    = 4'b0001 << Addr_M[1:0];
        w_wdata = {4{WD_M[7:0]}};
      end
      default: w_be = 4'b0000;
    endcase
    for (int b = 0; b < 4; b++) begin
      w_merged[8*b +: 8] = w_be[b] ? w_wdata[8*b +: 8] : w_word[8*b +: 8];
    end
    w_we = MemWrite_M & ~AddrErr_M;
  end

  for (genvar gw = 0; gw < WORDS; gw++) begin : g_word
    logic [31:0] r_word;
    // One storage word: cleared by reset (which beats a store), else takes the merged store data on a hit.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_word <= '0;
      end else if (w_we && (w_idx == IDX_BITS'(gw))) begin
        r_word <= w_merged;
      end
    end
    assign w_words[gw] = r_word;
  end

  // Fault capture: latest faulting PC and a count that saturates at 8'hFF.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err_pc  <= '0;
      r_err_cnt <= '0;
    end else if (AddrErr_M) begin
      r_err_pc <= PC_M;
      if (r_err_cnt != 8'hFF) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  assign ErrPC  = r_err_pc;
  assign ErrCnt = r_err_cnt;

endmodule

// File: tb/tb_dm_unit.sv
// tb_dm_unit: directed and randomized checks of dm_unit against a
// byte-addressed reference memory model.
module tb_dm_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite_M;
  logic [2:0]  MemOp_M;
  logic [31:0] Addr_M;
  logic [31:0] WD_M;
  logic [31:0] PC_M;
  logic [31:0] RD_M;
  logic        AddrErr_M;
  logic [31:0] ErrPC;
  logic [7:0]  ErrCnt;

  // clock / reset block
  always #5 clk = ~clk;

  dm_unit #(.ADDR_BITS(12)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemWrite_M (MemWrite_M),
    .MemOp_M    (MemOp_M),
    .Addr_M     (Addr_M),
    .WD_M       (WD_M),
    .PC_M       (PC_M),
    .RD_M       (RD_M),
    .AddrErr_M  (AddrErr_M),
    .ErrPC      (ErrPC),
    .ErrCnt     (ErrCnt)
  );

  int n_pass  = 0;
  int n_total = 0;

  // reference model: 4 KiB of bytes plus fault capture
  logic [7:0]  m_bytes [4096];
  logic [31:0] m_err_pc;
  int          m_err_cnt;

  logic [31:0] obs_rd;
  logic        obs_err;

  function automatic bit model_err(input bit we, input logic [2:0] op, input logic [31:0] a);
    if (op > 3'd4) return we;
    if (a >= 32'd4096) return 1'b1;
    if (op == 3'd0) return (a % 4) != 0;
    if (op == 3'd1 || op == 3'd2) return (a % 2) != 0;
    return 1'b0;
  endfunction

  function automatic int op_size(input logic [2:0] op);
    if (op == 3'd0) return 4;
    if (op == 3'd1 || op == 3'd2) return 2;
    return 1;
  endfunction

  function automatic logic [31:0] model_rd(input bit we, input logic [2:0] op, input logic [31:0] a);
    longint v;
    int     n;
    if (model_err(we, op, a) || op > 3'd4) return 32'h0;
    n = op_size(op);
    v = 0;
    for (int i = 0; i < n; i++) v += longint'(m_bytes[a + i]) << (8 * i);
    if ((op == 3'd1 || op == 3'd3) && n < 4 && v >= (longint'(1) << (8 * n - 1)))
      v = v - (longint'(1) << (8 * n)) + (longint'(1) << 32);
    return v[31:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4096; i++) m_bytes[i] = 8'h00;
    m_err_pc  = 32'h0;
    m_err_cnt = 0;
  endtask

  // driver: one access cycle; comb outputs checked mid-cycle, fault registers after the edge
  task automatic access(input bit we, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] pc);
    bit          e;
    logic [31:0] r;
    reset = 1'b0; MemWrite_M = we; MemOp_M = op; Addr_M = a; WD_M = wd; PC_M = pc;
    e = model_err(we, op, a);
    r = model_rd(we, op, a);
    @(negedge clk);
    obs_rd  = RD_M;
    obs_err = AddrErr_M;
    check("rd", RD_M, r);
    check("err", {31'b0, AddrErr_M}, {31'b0, e});
    @(posedge clk);
    if (e) begin
      m_err_pc = pc;
      if (m_err_cnt < 255) m_err_cnt++;
    end else if (we) begin
      for (int i = 0; i < op_size(op); i++) m_bytes[a + i] = 8'((wd >> (8 * i)) & 32'hFF);
    end
    #1;
    check("errpc", ErrPC, m_err_pc);
    check("errcnt", {24'b0, ErrCnt}, 32'(m_err_cnt));
  endtask

  // driver: one reset cycle, optionally with a store presented alongside it
  task automatic do_reset(input bit we, input logic [31:0] a, input logic [31:0] wd);
    reset = 1'b1; MemWrite_M = we; MemOp_M = 3'd0; Addr_M = a; WD_M = wd; PC_M = 32'h0;
    @(posedge clk);
    #1;
    model_clear();
    reset = 1'b0; MemWrite_M = 1'b0;
    check("rst_errpc", ErrPC, 32'h0);
    check("rst_errcnt", {24'b0, ErrCnt}, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sel;
    logic [31:0] ra;
    reset = 1'b1; MemWrite_M = 1'b0; MemOp_M = 3'd0; Addr_M = '0; WD_M = '0; PC_M = '0;
    model_clear();
    do_reset(1'b0, 32'h0, 32'h0);

    // reset state
    access(1'b0, 3'd0, 32'h10, 32'h0, 32'h100);
    check("r029_rd", obs_rd, 32'h0);
    check("r029_err", {31'b0, obs_err}, 32'h0);

    // word store, byte merge, byte/half loads
    access(1'b1, 3'd0, 32'h20, 32'h8899_AABB, 32'h104);
    access(1'b1, 3'd3, 32'h21, 32'h0000_0011, 32'h108);
    access(1'b0, 3'd0, 32'h20, 32'h0, 32'h10C);
    check("r030_lw", obs_rd, 32'h8899_11BB);
    access(1'b0, 3'd3, 32'h23, 32'h0, 32'h110);
    check("r030_lb", obs_rd, 32'hFFFF_FF88);
    access(1'b0, 3'd4, 32'h23, 32'h0, 32'h114);
    check("r030_lbu", obs_rd, 32'h0000_0088);
    access(1'b0, 3'd1, 32'h22, 32'h0, 32'h118);
    check("r030_lh", obs_rd, 32'hFFFF_8899);
    access(1'b0, 3'd2, 32'h20, 32'h0, 32'h11C);
    check("r030_lhu", obs_rd, 32'h0000_11BB);

    // upper half store
    access(1'b1, 3'd1, 32'h42, 32'hABCD_1234, 32'h120);
    access(1'b0, 3'd0, 32'h40, 32'h0, 32'h124);
    check("r031_lw", obs_rd, 32'h1234_0000);

    // misaligned store: faults, captured, no write
    access(1'b1, 3'd0, 32'h42, 32'hFFFF_FFFF, 32'h0000_3010);
    check("r032_err", {31'b0, obs_err}, 32'h1);
    check("r032_errpc", ErrPC, 32'h0000_3010);
    check("r032_errcnt", {24'b0, ErrCnt}, 32'h1);
    access(1'b0, 3'd0, 32'h40, 32'h0, 32'h128);
    check("r032_nowrite", obs_rd, 32'h1234_0000);

    // reserved op: bubble when loading, fault when storing
    access(1'b0, 3'd6, 32'h41, 32'h0, 32'h12C);
    check("resv_ld_err", {31'b0, obs_err}, 32'h0);
    access(1'b1, 3'd5, 32'h40, 32'h0, 32'h130);
    check("resv_st_err", {31'b0, obs_err}, 32'h1);

    // out of range, then saturation of the fault counter
    access(1'b0, 3'd0, 32'h1000, 32'h0, 32'h4000);
    check("r033_err", {31'b0, obs_err}, 32'h1);
    check("r033_rd", obs_rd, 32'h0);
    for (int i = 0; i < 300; i++) access(1'b0, 3'd0, 32'h1000, 32'h0, 32'h4000 + 32'(i));
    check("r033_sat", {24'b0, ErrCnt}, 32'hFF);

    // reset beats a same-cycle store and clears everything
    access(1'b1, 3'd0, 32'h4, 32'hCAFE_F00D, 32'h200);
    do_reset(1'b1, 32'h4, 32'hDEAD_BEEF);
    access(1'b0, 3'd0, 32'h4, 32'h0, 32'h204);
    check("r034_rst_lw", obs_rd, 32'h0);
    access(1'b0, 3'd0, 32'h40, 32'h0, 32'h208);
    check("r034_cleared", obs_rd, 32'h0);

    // read-old during a store, new value next cycle
    access(1'b1, 3'd0, 32'h8, 32'h1357_2468, 32'h20C);
    check("r034_old", obs_rd, 32'h0);
    access(1'b0, 3'd0, 32'h8, 32'h0, 32'h210);
    check("r034_new", obs_rd, 32'h1357_2468);

    // back-to-back stores to one word
    access(1'b1, 3'd0, 32'hC, 32'h1122_3344, 32'h214);
    access(1'b1, 3'd3, 32'hD, 32'h0000_00AA, 32'h218);
    access(1'b0, 3'd0, 32'hC, 32'h0, 32'h21C);
    check("r023_b2b", obs_rd, 32'h1122_AA44);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 8)       ra = 32'($urandom_range(0, 127));
      else if (sel == 8) ra = 32'($urandom_range(4088, 4103));
      else               ra = $urandom;
      access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra, $urandom, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dm_unit.md
DM_UNIT -- requirements
Module: dm_unit

Interface
REQ-001 Parameter: ADDR_BITS, default 12, byte-address width of the memory, giving 2^(ADDR_BITS-2) 32-bit words (1024 at default).
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 MemWrite_M  input  1  store request for the current M-stage instruction.
REQ-005 MemOp_M  input  3  access type: 000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned, 101-111 reserved.
REQ-006 Addr_M  input  32  byte address (ALU result from the E/M register).
REQ-007 WD_M  input  32  store data, already forwarded; the low byte/half is used for sb/sh.
REQ-008 PC_M  input  32  PC of the M-stage instruction; debug and error capture only.
REQ-009 RD_M  output  32  load data, extended per MemOp_M; feeds the M/W register write-data input.
REQ-010 AddrErr_M  output  1  combinational flag: the current access is misaligned, out of range, or reserved.
REQ-011 ErrPC  output  32  registered PC of the most recent faulting access.
REQ-012 ErrCnt  output  8  registered count of faulting accesses.

Function
REQ-013 Storage is a 2^(ADDR_BITS-2) x 32 array, indexed by Addr_M[ADDR_BITS-1:2].
REQ-014 Reads are combinational and reflect all writes committed at earlier edges; a same-cycle store is not visible until after the edge (read-old).
REQ-015 Word load: RD_M = word.
- Half load selects the half by Addr_M[1] (1 = bits 31:16) and sign-extends (001) or zero-extends (010).
- Byte load selects the byte by Addr_M[1:0] (3 = bits 31:24) and sign-extends (011) or zero-extends (100).
REQ-016 Store (MemWrite_M=1) updates only the addressed lanes at the rising edge:
- sw writes all 4 bytes.
- sh writes WD_M[15:0] into the half selected by Addr_M[1].
- sb writes WD_M[7:0] into the byte selected by Addr_M[1:0].
- Unselected bytes are unchanged.
REQ-017 MemOp 101-111 with MemWrite_M=1 is invalid; with MemWrite_M=0 it means "no memory access": RD_M=0, AddrErr_M=0.
REQ-018 Misaligned: word with Addr_M[1:0]!=0, or half with Addr_M[0]!=0.
REQ-019 Out of range: any of Addr_M[31:ADDR_BITS] nonzero.
REQ-020 AddrErr_M=1 when (MemWrite_M=1 or MemOp_M<=100) and the access is misaligned, out of range, or an invalid store (REQ-017).
REQ-021 While AddrErr_M=1: no array write occurs and RD_M=0.
REQ-022 Each edge with AddrErr_M=1 and reset=0: ErrPC <= PC_M, and ErrCnt increments, saturating at 8'hFF (no wrap).
REQ-023 Back-to-back stores to the same word in consecutive cycles both take effect in order; the second store's unselected bytes keep the first store's values.
REQ-024 Latency: load data is valid in the same cycle as the address; store takes effect at the next rising edge.

Reset
REQ-025 reset=1 at a rising edge clears every array word to 0, ErrPC to 0, and ErrCnt to 0.
REQ-026 A store presented in the reset cycle is discarded; reset has priority over the write.
REQ-027 RD_M and AddrErr_M remain combinational during reset and reflect the cleared array after the edge.
REQ-028 No power-up state is relied upon beyond an initial reset pulse; the initial value equals the reset value.

Verification
REQ-029 Reset, then lw at 0x0000_0010 -> RD_M=0x0000_0000, AddrErr_M=0.
REQ-030 Store and byte/half loads at 0x0000_0020:
- sw 0x8899_AABB to 0x0000_0020, then sb 0x11 to 0x0000_0021 -> lw gives 0x8899_11BB.
- lb at 0x0000_0023 -> 0xFFFF_FF88; lbu at 0x0000_0023 -> 0x0000_0088.
- lh at 0x0000_0022 -> 0xFFFF_8899; lhu at 0x0000_0020 -> 0x0000_11BB.
REQ-031 sh 0x1234 to 0x0000_0042, then lw at 0x0000_0040 -> 0x1234_0000.
REQ-032 sw to 0x0000_0042 with PC_M=0x0000_3010 -> AddrErr_M=1 and no write (a following lw at 0x0000_0040 is unchanged); after the edge, ErrPC=0x0000_3010 and ErrCnt increments by 1.
REQ-033 lw at 0x0000_1000 (ADDR_BITS=12) -> AddrErr_M=1, RD_M=0; 300 consecutive faulting cycles -> ErrCnt=0xFF.
REQ-034 Reset mid-operation:
- sw 0xDEAD_BEEF to 0x0000_0004 together with reset=1 -> lw at 0x0000_0004 afterwards gives 0.
- Same-cycle read during a store returns the old value; the next cycle returns the new value.
